// File: rtl/bridge_arb_pkg.sv
// bridge_arb_pkg: shared FSM state type and one-hot helpers for the bridge arbiter
package bridge_arb_pkg;
  localparam int MAX_VEC = 64;
  typedef enum logic {ARB, LOCKED} state_t;
  function automatic logic is_onehot(input logic [MAX_VEC-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction
  function automatic int onehot_to_idx(input logic [MAX_VEC-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < MAX_VEC; i++)
      if (v[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/bridge_rr_arb_ctrl_if.sv
// bridge_rr_arb_ctrl_if: master-side request bundle plus bridge request/response path
interface bridge_rr_arb_ctrl_if #(
  parameter int N_MASTER   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH/8,
  parameter int AUX_WIDTH  = 32,
  parameter int ID_WIDTH   = N_MASTER
);
  logic [N_MASTER-1:0]                 data_req_i;
  logic [N_MASTER-1:0][ADDR_WIDTH-1:0] data_add_i;
  logic [N_MASTER-1:0]                 data_wen_i;
  logic [N_MASTER-1:0][DATA_WIDTH-1:0] data_wdata_i;
  logic [N_MASTER-1:0][BE_WIDTH-1:0]   data_be_i;
  logic [N_MASTER-1:0][AUX_WIDTH-1:0]  data_aux_i;
  logic [N_MASTER-1:0]                 data_gnt_o;
  logic                                data_req_o;
  logic [ADDR_WIDTH-1:0]               data_add_o;
  logic                                data_wen_o;
  logic [DATA_WIDTH-1:0]               data_wdata_o;
  logic [BE_WIDTH-1:0]                 data_be_o;
  logic [AUX_WIDTH-1:0]                data_aux_o;
  logic [ID_WIDTH-1:0]                 data_ID_o;
  logic                                data_gnt_i;
  logic                                data_r_valid_i;
  logic [ID_WIDTH-1:0]                 data_r_ID_i;
  logic [N_MASTER-1:0]                 data_r_valid_o;
  logic                                otx_busy_o;
  logic                                err_o;
  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_aux_i,
    input  data_gnt_i, data_r_valid_i, data_r_ID_i,
    output data_gnt_o, data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
    output data_aux_o, data_ID_o, data_r_valid_o, otx_busy_o, err_o
  );
  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_aux_i,
    output data_gnt_i, data_r_valid_i, data_r_ID_i,
    input  data_gnt_o, data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
    input  data_aux_o, data_ID_o, data_r_valid_o, otx_busy_o, err_o
  );
endinterface

// File: rtl/bridge_rr_prio_sel.sv
// bridge_rr_prio_sel: find first set bit of eligible, scanning upward from ptr with wrap-around
module bridge_rr_prio_sel #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  int j;
  logic [IDX_W-1:0] jj;
  always_comb begin
    valid = 1'b0;
    idx = '0;
    j = 0;
    jj = '0;
    // descending scan so the candidate closest to ptr is written last and wins
    for (int k = N-1; k >= 0; k--) begin
      j = int'(ptr) + k;
      j = (j >= N) ? j - N : j;
      jj = IDX_W'(j);
      if (eligible[jj]) begin
        valid = 1'b1;
        idx = jj;
      end
    end
  end
endmodule

// File: rtl/bridge_rr_arb_ctrl.sv
// bridge_rr_arb_ctrl: round-robin sharing of one bridge port with stall lock,
// per-master outstanding throttle and one-hot response routing
module bridge_rr_arb_ctrl
  import bridge_arb_pkg::*;
#(
  parameter int N_MASTER        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = DATA_WIDTH/8,
  parameter int AUX_WIDTH       = 32,
  parameter int ID_WIDTH        = N_MASTER,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING+1)
) (
  input logic clk,
  input logic rst,
  bridge_rr_arb_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(N_MASTER);
  state_t state, state_n;
  logic [IDX_W-1:0] ptr, lock_idx, rr_idx, w, rsp_idx;
  logic [N_MASTER-1:0][CNT_WIDTH-1:0] cnt;
  logic [N_MASTER-1:0] eligible, busy_vec, inc, dec;
  logic rr_valid, hold, lock_err, req, hs, rsp_onehot, rsp_err, err;
  always_comb begin
    eligible = '0;
    busy_vec = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      eligible[i] = bus.data_req_i[i] && (cnt[i] < CNT_WIDTH'(MAX_OUTSTANDING));
      busy_vec[i] = cnt[i] != '0;
    end
  end
  bridge_rr_prio_sel #(.N(N_MASTER), .IDX_W(IDX_W)) u_sel (
    .eligible(eligible),
    .ptr(ptr),
    .valid(rr_valid),
    .idx(rr_idx)
  );
  // a locked master keeps the port even at its limit; dropping req falls back to normal arbitration
  always_comb begin
    hold = (state == LOCKED) && bus.data_req_i[lock_idx];
    lock_err = (state == LOCKED) && !bus.data_req_i[lock_idx];
    w = hold ? lock_idx : rr_idx;
    req = !rst && (hold || rr_valid);
    hs = req && bus.data_gnt_i;
    state_n = (req && !hs) ? LOCKED : ARB;
  end
  always_comb begin
    rsp_onehot = is_onehot(MAX_VEC'(bus.data_r_ID_i));
    rsp_idx = IDX_W'(onehot_to_idx(MAX_VEC'(bus.data_r_ID_i)));
    rsp_err = bus.data_r_valid_i && (!rsp_onehot || !busy_vec[rsp_idx]);
    inc = hs ? (N_MASTER'(1) << w) : '0;
    dec = (bus.data_r_valid_i && rsp_onehot) ? (N_MASTER'(bus.data_r_ID_i) & busy_vec) : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ARB;
      ptr <= '0;
      lock_idx <= '0;
      err <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (hs) ptr <= (w == IDX_W'(N_MASTER-1)) ? '0 : w + 1'b1;
      if (req && !hs) lock_idx <= w;
      if (rsp_err || lock_err) err <= 1'b1;
      for (int i = 0; i < N_MASTER; i++)
        if (inc[i] != dec[i]) cnt[i] <= inc[i] ? cnt[i] + 1'b1 : cnt[i] - 1'b1;
    end
  assign bus.data_req_o     = req;
  assign bus.data_gnt_o     = inc;
  assign bus.data_add_o     = req ? bus.data_add_i[w] : '0;
  assign bus.data_wen_o     = req ? bus.data_wen_i[w] : 1'b0;
  assign bus.data_wdata_o   = req ? bus.data_wdata_i[w] : '0;
  assign bus.data_be_o      = req ? bus.data_be_i[w] : '0;
  assign bus.data_aux_o     = req ? bus.data_aux_i[w] : '0;
  assign bus.data_ID_o      = req ? ID_WIDTH'(1) << w : '0;
  assign bus.data_r_valid_o = (!rst && bus.data_r_valid_i) ? N_MASTER'(bus.data_r_ID_i) : '0;
  assign bus.otx_busy_o     = |busy_vec;
  assign bus.err_o          = err;
endmodule

// File: tb/tb_bridge_rr_arb_ctrl.sv
// tb_bridge_rr_arb_ctrl: table-driven cycle vectors through a scoreboard queue, plus reset-mid-stall sequence
module tb_bridge_rr_arb_ctrl;
  typedef struct {
    logic [3:0] req;
    logic       gnt;
    logic       rv;
    logic [3:0] rid;
    logic       exp_req;
    logic [3:0] exp_gnt;
    logic [3:0] exp_id;
    logic [3:0] exp_rv;
    logic       exp_busy;
    logic       exp_err;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  vec_t tab[33];
  vec_t sb[$];
  logic [31:0] add_tab[4];
  logic [31:0] wd_tab[4];
  logic [31:0] aux_tab[4];
  bridge_rr_arb_ctrl_if #(.N_MASTER(4)) bus ();
  bridge_rr_arb_ctrl #(.N_MASTER(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [3:0] req, input logic gnt, input logic rv, input logic [3:0] rid);
    bus.data_req_i = req;
    bus.data_gnt_i = gnt;
    bus.data_r_valid_i = rv;
    bus.data_r_ID_i = rid;
  endtask
  initial begin
    vec_t e;
    logic [31:0] ea, ew, ex;
    logic [3:0] eb;
    logic ewen;
    for (int i = 0; i < 4; i++) begin
      add_tab[i] = 32'h1000 + i;
      wd_tab[i] = 32'hA0A0_0000 + i;
      aux_tab[i] = 32'h55 + i;
      bus.data_add_i[i] = add_tab[i];
      bus.data_wdata_i[i] = wd_tab[i];
      bus.data_aux_i[i] = aux_tab[i];
      bus.data_be_i[i] = 4'(1 << i);
      bus.data_wen_i[i] = i[0];
    end
    //          req    gnt   rv    rid    ereq  egnt   eid    erv    busy  err
    tab[0]  = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 4'h1, 4'h1, 4'h0, 1'b0, 1'b0};
    tab[1]  = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 4'h2, 4'h2, 4'h0, 1'b1, 1'b0};
    tab[2]  = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 4'h4, 4'h4, 4'h0, 1'b1, 1'b0};
    tab[3]  = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 4'h8, 4'h8, 4'h0, 1'b1, 1'b0};
    tab[4]  = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 4'h1, 4'h1, 4'h0, 1'b1, 1'b0};
    tab[5]  = '{4'h0, 1'b0, 1'b1, 4'h1, 1'b0, 4'h0, 4'h0, 4'h1, 1'b1, 1'b0};
    tab[6]  = '{4'h0, 1'b0, 1'b1, 4'h1, 1'b0, 4'h0, 4'h0, 4'h1, 1'b1, 1'b0};
    tab[7]  = '{4'h0, 1'b0, 1'b1, 4'h2, 1'b0, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0};
    tab[8]  = '{4'h0, 1'b0, 1'b1, 4'h4, 1'b0, 4'h0, 4'h0, 4'h4, 1'b1, 1'b0};
    tab[9]  = '{4'h0, 1'b0, 1'b1, 4'h8, 1'b0, 4'h0, 4'h0, 4'h8, 1'b1, 1'b0};
    tab[10] = '{4'h8, 1'b1, 1'b0, 4'h0, 1'b1, 4'h8, 4'h8, 4'h0, 1'b0, 1'b0};
    tab[11] = '{4'h2, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 4'h2, 4'h0, 1'b1, 1'b0};
    tab[12] = '{4'h3, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 4'h2, 4'h0, 1'b1, 1'b0};
    tab[13] = '{4'h3, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 4'h2, 4'h0, 1'b1, 1'b0};
    tab[14] = '{4'h3, 1'b1, 1'b0, 4'h0, 1'b1, 4'h2, 4'h2, 4'h0, 1'b1, 1'b0};
    tab[15] = '{4'h5, 1'b1, 1'b0, 4'h0, 1'b1, 4'h4, 4'h4, 4'h0, 1'b1, 1'b0};
    tab[16] = '{4'h1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h1, 4'h1, 4'h0, 1'b1, 1'b0};
    tab[17] = '{4'h1, 1'b1, 1'b1, 4'h1, 1'b1, 4'h1, 4'h1, 4'h1, 1'b1, 1'b0};
    tab[18] = '{4'h0, 1'b0, 1'b1, 4'h1, 1'b0, 4'h0, 4'h0, 4'h1, 1'b1, 1'b0};
    tab[19] = '{4'h0, 1'b0, 1'b1, 4'h2, 1'b0, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0};
    tab[20] = '{4'h0, 1'b0, 1'b1, 4'h4, 1'b0, 4'h0, 4'h0, 4'h4, 1'b1, 1'b0};
    tab[21] = '{4'h0, 1'b0, 1'b1, 4'h8, 1'b0, 4'h0, 4'h0, 4'h8, 1'b1, 1'b0};
    tab[22] = '{4'h4, 1'b1, 1'b0, 4'h0, 1'b1, 4'h4, 4'h4, 4'h0, 1'b0, 1'b0};
    tab[23] = '{4'h4, 1'b1, 1'b0, 4'h0, 1'b1, 4'h4, 4'h4, 4'h0, 1'b1, 1'b0};
    tab[24] = '{4'h4, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
    tab[25] = '{4'h4, 1'b1, 1'b1, 4'h4, 1'b0, 4'h0, 4'h0, 4'h4, 1'b1, 1'b0};
    tab[26] = '{4'h4, 1'b1, 1'b0, 4'h0, 1'b1, 4'h4, 4'h4, 4'h0, 1'b1, 1'b0};
    tab[27] = '{4'h0, 1'b0, 1'b1, 4'h6, 1'b0, 4'h0, 4'h0, 4'h6, 1'b1, 1'b0};
    tab[28] = '{4'h4, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1};
    tab[29] = '{4'h0, 1'b0, 1'b1, 4'h4, 1'b0, 4'h0, 4'h0, 4'h4, 1'b1, 1'b1};
    tab[30] = '{4'h0, 1'b0, 1'b1, 4'h4, 1'b0, 4'h0, 4'h0, 4'h4, 1'b1, 1'b1};
    tab[31] = '{4'h0, 1'b0, 1'b1, 4'h1, 1'b0, 4'h0, 4'h0, 4'h1, 1'b0, 1'b1};
    tab[32] = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
    drive(4'hF, 1'b1, 1'b1, 4'h1);
    #2;
    chk("rst req_o", bus.data_req_o, 0);
    chk("rst gnt_o", bus.data_gnt_o, 0);
    chk("rst ID_o", bus.data_ID_o, 0);
    chk("rst r_valid_o", bus.data_r_valid_o, 0);
    chk("rst busy", bus.otx_busy_o, 0);
    chk("rst err", bus.err_o, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 33; n++) begin
      if (n > 0) @(negedge clk);
      drive(tab[n].req, tab[n].gnt, tab[n].rv, tab[n].rid);
      sb.push_back(tab[n]);
      #1;
      e = sb.pop_front();
      ea = '0; ew = '0; ex = '0; eb = '0; ewen = 1'b0;
      for (int k = 0; k < 4; k++)
        if (e.exp_id == 4'(1 << k)) begin
          ea = add_tab[k];
          ew = wd_tab[k];
          ex = aux_tab[k];
          eb = 4'(1 << k);
          ewen = k[0];
        end
      chk($sformatf("v%0d req_o", n), bus.data_req_o, e.exp_req);
      chk($sformatf("v%0d gnt_o", n), bus.data_gnt_o, e.exp_gnt);
      chk($sformatf("v%0d ID_o", n), bus.data_ID_o, e.exp_id);
      chk($sformatf("v%0d r_valid_o", n), bus.data_r_valid_o, e.exp_rv);
      chk($sformatf("v%0d busy", n), bus.otx_busy_o, e.exp_busy);
      chk($sformatf("v%0d err", n), bus.err_o, e.exp_err);
      chk($sformatf("v%0d fields", n), {bus.data_add_o, bus.data_wdata_o}, {ea, ew});
      chk($sformatf("v%0d side", n), {bus.data_aux_o, bus.data_be_o, bus.data_wen_o}, {ex, eb, ewen});
    end
    // stall M2 into LOCKED, then hit it with an asynchronous reset
    @(negedge clk);
    drive(4'h4, 1'b0, 1'b0, 4'h0);
    #1;
    chk("stall ID_o", bus.data_ID_o, 4'h4);
    @(negedge clk);
    drive(4'hF, 1'b1, 1'b1, 4'h1);
    #1;
    chk("locked ID_o", bus.data_ID_o, 4'h4);
    chk("locked add_o", bus.data_add_o, 32'h1002);
    #1;
    rst = 1'b1;
    #1;
    chk("arst req_o", bus.data_req_o, 0);
    chk("arst gnt_o", bus.data_gnt_o, 0);
    chk("arst ID_o", bus.data_ID_o, 0);
    chk("arst add_o", bus.data_add_o, 0);
    chk("arst r_valid_o", bus.data_r_valid_o, 0);
    chk("arst err", bus.err_o, 0);
    chk("arst busy", bus.otx_busy_o, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'hF, 1'b1, 1'b0, 4'h0);
    #1;
    chk("post-rst ID_o", bus.data_ID_o, 4'h1);
    chk("post-rst gnt_o", bus.data_gnt_o, 4'h1);
    chk("post-rst busy", bus.otx_busy_o, 0);
    @(negedge clk);
    drive(4'h0, 1'b0, 1'b1, 4'h4);
    #1;
    chk("zero-target busy", bus.otx_busy_o, 1);
    chk("zero-target err pre", bus.err_o, 0);
    @(negedge clk);
    drive(4'h0, 1'b0, 1'b0, 4'h0);
    #1;
    chk("zero-target err", bus.err_o, 1);
    chk("zero-target cnt kept", bus.otx_busy_o, 1);
    @(negedge clk);
    drive(4'h0, 1'b0, 1'b1, 4'h1);
    @(negedge clk);
    drive(4'h0, 1'b0, 1'b0, 4'h0);
    #1;
    chk("drain busy", bus.otx_busy_o, 0);
    chk("err sticky", bus.err_o, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
